// File: rtl/ascon_pkg.sv
// ascon_pkg
// Shared constants and helpers for the Ascon round-constant scheduler.
//   - round-count limits and the legal round counts (6, 8, 12)
//   - scheduler state encoding
//   - ascon_rc(): constant for table index i, (0xF0 - 15*i) mod 256
//   - rounds_legal(): is a requested round count supported
package ascon_pkg;

    localparam int          ASCON_MAX_ROUNDS = 12;
    localparam int          ROUND_W          = 4;
    localparam logic [7:0]  RC_BASE          = 8'hF0;
    localparam logic [7:0]  RC_STEP          = 8'h0F;

    localparam logic [ROUND_W-1:0] ROUNDS_6  = 4'd6;
    localparam logic [ROUND_W-1:0] ROUNDS_8  = 4'd8;
    localparam logic [ROUND_W-1:0] ROUNDS_12 = 4'd12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    // 8-bit modular arithmetic gives the wrap-around of the constant table.
    function automatic logic [7:0] ascon_rc(input logic [ROUND_W-1:0] idx);
        logic [7:0] prod;
        prod = {4'b0000, idx} * RC_STEP;
        return RC_BASE - prod;
    endfunction

    function automatic logic rounds_legal(input logic [ROUND_W-1:0] r);
        return (r == ROUNDS_6) || (r == ROUNDS_8) || (r == ROUNDS_12);
    endfunction

endpackage

// File: rtl/ascon_rc_lane.sv
// ascon_rc_lane
// One lane of the constant generator: returns the round constant for the
// given table index, or 0x00 when the lane carries no real round (so an
// out-of-range index never reaches the table).
//   idx   in  ROUND_W  table index for this lane
//   valid in  1        lane carries a real round
//   rc    out 8        constant or 0x00
module ascon_rc_lane
    import ascon_pkg::*;
(
    input  logic [ROUND_W-1:0] idx,
    input  logic               valid,
    output logic [7:0]         rc
);

    // Constant lookup gated by the lane mask.
    always_comb begin
        rc = 8'h00;
        if (valid) begin
            rc = ascon_rc(idx);
        end else begin
            rc = 8'h00;
        end
    end

endmodule

// File: rtl/ascon_rc_sched.sv
// ascon_rc_sched
// Sequential round-constant scheduler for the Ascon permutation. After a
// start request it streams ceil(r/UNROLL) beats of UNROLL constants each to
// the round datapath over valid/ready, then pulses done_o.
//   clk, rst        clock, synchronous active-high reset
//   start_i         request a schedule (IDLE only)
//   rounds_i        round count 6/8/12, others fall back to DEFAULT_ROUNDS
//   abort_i         cancel a running schedule
//   busy_o          scheduler in RUN
//   rc_valid_o      beat valid
//   rc_ready_i      datapath accepts the beat
//   rc_o            UNROLL constants, lane k at [8k+7:8k]
//   lane_mask_o     lane k carries a real round
//   last_o          current beat is the final group
//   done_o          one-cycle pulse after the final beat is accepted
//   cfg_err_o       last accepted start used an illegal rounds_i
// All outputs are registers; their next values are derived from the next
// state so the outputs never depend combinationally on rc_ready_i.
module ascon_rc_sched
    import ascon_pkg::*;
#(
    parameter int UNROLL         = 1,
    parameter int DEFAULT_ROUNDS = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ROUND_W-1:0]    rounds_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  rc_valid_o,
    input  logic                  rc_ready_i,
    output logic [8*UNROLL-1:0]   rc_o,
    output logic [UNROLL-1:0]     lane_mask_o,
    output logic                  last_o,
    output logic                  done_o,
    output logic                  cfg_err_o
);

    generate
        if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
            $error("ascon_rc_sched: UNROLL must be in 1..4");
        end
    endgenerate

    localparam logic [ROUND_W-1:0] UNROLL_W  = ROUND_W'(UNROLL);
    localparam logic [ROUND_W-1:0] DEFAULT_W = ROUND_W'(DEFAULT_ROUNDS);
    localparam logic [ROUND_W-1:0] MAX_W     = ROUND_W'(ASCON_MAX_ROUNDS);

    sched_state_t          state_r, state_s;
    logic [ROUND_W-1:0]    idx_r, idx_s;
    logic [ROUND_W-1:0]    rem_r, rem_s;
    logic                  cfg_err_s;
    logic                  done_s;
    logic [ROUND_W-1:0]    rsel_s;
    logic [ROUND_W-1:0]    step_s;
    logic                  run_s;
    logic [8*UNROLL-1:0]   rc_s;
    logic [UNROLL-1:0]     mask_s;
    logic                  last_s;

    // Next-state, counter and handshake decisions.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        rem_s     = rem_r;
        cfg_err_s = cfg_err_o;
        done_s    = 1'b0;
        rsel_s    = rounds_legal(rounds_i) ? rounds_i : DEFAULT_W;
        step_s    = (rem_r < UNROLL_W) ? rem_r : UNROLL_W;
        case (state_r)
            ST_IDLE: begin
                // abort_i blocks a simultaneous start_i.
                if (start_i && !abort_i) begin
                    idx_s     = MAX_W - rsel_s;
                    rem_s     = rsel_s;
                    cfg_err_s = !rounds_legal(rounds_i);
                    state_s   = ST_RUN;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort wins over a transfer in the same cycle.
                if (abort_i) begin
                    state_s = ST_IDLE;
                    idx_s   = '0;
                    rem_s   = '0;
                end else if (rc_ready_i) begin
                    idx_s = idx_r + UNROLL_W;
                    rem_s = rem_r - step_s;
                    if (last_o) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
                rem_s   = '0;
            end
        endcase
    end

    assign run_s  = (state_s == ST_RUN);
    assign last_s = run_s && (rem_s <= UNROLL_W);

    generate
        for (genvar k = 0; k < UNROLL; k++) begin : g_lane
            assign mask_s[k] = run_s && (ROUND_W'(k) < rem_s);
            ascon_rc_lane u_lane (
                .idx   (idx_s + ROUND_W'(k)),
                .valid (mask_s[k]),
                .rc    (rc_s[8*k +: 8])
            );
        end
    endgenerate

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            rem_r       <= '0;
            busy_o      <= 1'b0;
            rc_valid_o  <= 1'b0;
            rc_o        <= '0;
            lane_mask_o <= '0;
            last_o      <= 1'b0;
            done_o      <= 1'b0;
            cfg_err_o   <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            rem_r       <= rem_s;
            busy_o      <= run_s;
            rc_valid_o  <= run_s;
            rc_o        <= rc_s;
            lane_mask_o <= mask_s;
            last_o      <= last_s;
            done_o      <= done_s;
            cfg_err_o   <= cfg_err_s;
        end
    end

endmodule

// File: tb/tb_ascon_rc_sched.sv
// tb_ascon_rc_sched
// Drives one scheduler instance per UNROLL value (1..4) in turn, with
// directed and $urandom stimulus, and compares every cycle against a
// queue-based reference model of the round-constant schedule.
module tb_ascon_rc_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start_v = 4'b0000;
    logic [3:0]  abort_v = 4'b0000;
    logic        ready_r = 1'b0;
    logic [3:0]  rounds_v [4];

    logic [3:0]  busy_w, valid_w, last_w, done_w, err_w;
    logic [31:0] rc_w   [4];
    logic [3:0]  mask_w [4];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            logic [8*(g+1)-1:0] rc_loc;
            logic [g:0]         mask_loc;
            ascon_rc_sched #(.UNROLL(g + 1), .DEFAULT_ROUNDS(12)) dut (
                .clk         (clk),
                .rst         (rst),
                .start_i     (start_v[g]),
                .rounds_i    (rounds_v[g]),
                .abort_i     (abort_v[g]),
                .busy_o      (busy_w[g]),
                .rc_valid_o  (valid_w[g]),
                .rc_ready_i  (ready_r),
                .rc_o        (rc_loc),
                .lane_mask_o (mask_loc),
                .last_o      (last_w[g]),
                .done_o      (done_w[g]),
                .cfg_err_o   (err_w[g])
            );
            assign rc_w[g]   = 32'(rc_loc);
            assign mask_w[g] = 4'(mask_loc);
        end
    endgenerate

    int n_checks = 0;
    int n_errors = 0;
    int act = 0;

    // Reference model state: remaining table indices of the current call.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;
    int pend [$];

    function automatic int rc_ref(input int i);
        return (240 - 15 * i) % 256;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s u=%0d t=%0t got=%h exp=%h", tag, act + 1, $time, got, exp);
        end
    endtask

    task automatic model_update(input bit st, input int rnd, input bit rdy, input bit ab, input bit rs);
        int r;
        int u;
        u = act + 1;
        if (rs) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            pend.delete();
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (st && !ab) begin
                m_err = !(rnd == 6 || rnd == 8 || rnd == 12);
                r = m_err ? 12 : rnd;
                pend.delete();
                for (int i = 12 - r; i < 12; i++) pend.push_back(i);
                m_busy = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (ab) begin
                m_busy = 1'b0;
                pend.delete();
            end else if (rdy) begin
                for (int j = 0; j < u; j++) if (pend.size() > 0) void'(pend.pop_front());
                if (pend.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        logic [31:0] rc_e;
        logic [3:0]  mask_e;
        int n;
        int u;
        u = act + 1;
        rc_e = 32'h0; mask_e = 4'h0;
        n = (pend.size() < u) ? pend.size() : u;
        if (m_busy) begin
            for (int j = 0; j < n; j++) begin
                rc_e   = rc_e | (32'(rc_ref(pend[j])) << (8 * j));
                mask_e = mask_e | (4'b0001 << j);
            end
        end
        check_val("rc", 64'(rc_w[act]), 64'(rc_e));
        check_val("mask", 64'(mask_w[act]), 64'(mask_e));
        check_val("valid_busy", 64'({valid_w[act], busy_w[act]}), 64'({m_busy, m_busy}));
        check_val("last", 64'(last_w[act]), 64'(m_busy && pend.size() <= u));
        check_val("done", 64'(done_w[act]), 64'(m_done));
        check_val("cfg_err", 64'(err_w[act]), 64'(m_err));
    endtask

    task automatic cycle(input bit st, input int rnd, input bit rdy, input bit ab, input bit rs);
        start_v        = 4'(st) << act;
        abort_v        = 4'(ab) << act;
        rounds_v[act]  = 4'(rnd);
        ready_r        = rdy;
        rst            = rs;
        @(posedge clk);
        model_update(st, rnd, rdy, ab, rs);
        #1;
        compare_outputs();
    endtask

    // One call: start, then random ready/start noise until the model idles.
    task automatic run_call(input int rnd, input int rdy_pct, input int abort_at,
                            input int rst_at, input int first_exp);
        cycle(1'b1, rnd, 1'b1, 1'b0, 1'b0);
        if (first_exp >= 0) check_val("first_rc", 64'(rc_w[act][7:0]), 64'(first_exp));
        for (int c = 0; c < 80 && m_busy; c++) begin
            cycle(1'($urandom % 2), int'($urandom % 16), ($urandom % 100) < rdy_pct,
                  c == abort_at, c == rst_at);
        end
        if (m_busy) check_val("timeout", 64'd1, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rounds_v[i] = 4'd0;
        for (int a = 0; a < 4; a++) begin
            act = a;
            cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
            run_call(6, 100, -1, -1, 8'h96);
            run_call(12, 100, -1, -1, 8'hF0);
            run_call(8, 100, -1, -1, 8'hB4);
            run_call(8, 50, -1, -1, 8'hB4);
            run_call(5, 100, -1, -1, 8'hF0);
            run_call(6, 100, -1, -1, 8'h96);
            // abort in IDLE wins over start
            cycle(1'b1, 12, 1'b1, 1'b1, 1'b0);
            cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
            run_call(8, 100, 1, -1, 8'hB4);
            run_call(12, 100, -1, 2, 8'hF0);
            run_call(12, 100, -1, -1, 8'hF0);
            for (int k = 0; k < 25; k++) begin
                run_call(int'($urandom % 16), 70,
                         ($urandom % 4 == 0) ? int'($urandom % 6) : -1,
                         ($urandom % 8 == 0) ? int'($urandom % 6) : -1, -1);
                if ($urandom % 3 == 0) cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
